// File: rtl/game_pkg.sv
// Shared types and widths for the keypad password checker.
// Holds the FSM encoding and the digit/code widths.
package game_pkg;

  localparam int DIGIT_W = 4;
  localparam int CODE_W  = 16;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CHECK,
    S_GRANTED,
    S_DENIED,
    S_LOCKED
  } state_t;

  function automatic logic is_bcd(
    input logic [DIGIT_W-1:0] d
  );
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Lockout down-counter: loads a start value, then counts to zero.
// done is high whenever the count reads zero.
module lock_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign done  = (r_count == '0);

endmodule

// File: rtl/password_check.sv
// Four-digit BCD keypad lock with retry limit and timed lockout.
// FSM, entry shift register and tries counter; timer is external.
module password_check
  import game_pkg::*;
#(
  parameter logic [CODE_W-1:0] PASSWORD    = 16'h1357,
  parameter int                MAX_TRIES   = 3,
  parameter int                LOCK_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enter_pulse,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [1:0]         digit_count,
  output logic [CODE_W-1:0]  entry,
  output logic               pass_ok,
  output logic               pass_fail,
  output logic               digit_err,
  output logic               locked,
  output logic [1:0]         tries_left
);

  localparam int TW = $clog2(LOCK_CYCLES);
  localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);

  state_t            r_state, w_state;
  logic [CODE_W-1:0] r_entry, w_entry;
  logic [1:0]        r_count, w_count;
  logic [1:0]        r_tries, w_tries;
  logic              r_pass_ok, w_pass_ok;
  logic              r_pass_fail, w_pass_fail;
  logic              r_digit_err, w_digit_err;
  logic              r_locked, w_locked;
  logic              w_load;
  logic              w_done;
  logic [TW-1:0]     w_lock_count_unused;

  lock_timer #(
    .WIDTH (TW)
  ) u_lock_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (LOAD_VAL),
    .count    (w_lock_count_unused),
    .done     (w_done)
  );

  always_comb begin
    w_state     = r_state;
    w_entry     = r_entry;
    w_count     = r_count;
    w_tries     = r_tries;
    w_pass_ok   = r_pass_ok;
    w_pass_fail = 1'b0;
    w_digit_err = 1'b0;
    w_locked    = r_locked;
    w_load      = 1'b0;
    unique case (r_state)
      S_COLLECT: begin
        if (enter_pulse) begin
          if (!is_bcd(digit_in)) begin
            w_digit_err = 1'b1;
          end else begin
            w_entry = {r_entry[CODE_W-DIGIT_W-1:0], digit_in};
            w_count = r_count + 2'd1;
            if (r_count == 2'd3) begin
              w_state = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (r_entry == PASSWORD) begin
          w_state   = S_GRANTED;
          w_pass_ok = 1'b1;
        end else begin
          w_state     = S_DENIED;
          w_pass_fail = 1'b1;
          w_tries     = r_tries - 2'd1;
        end
      end
      S_DENIED: begin
        if (r_tries == 2'd0) begin
          w_state  = S_LOCKED;
          w_locked = 1'b1;
          w_load   = 1'b1;
        end else begin
          w_state = S_COLLECT;
          w_entry = '0;
        end
      end
      S_LOCKED: begin
        if (w_done) begin
          w_state  = S_COLLECT;
          w_locked = 1'b0;
          w_tries  = TRIES_INIT;
          w_entry  = '0;
        end
      end
      S_GRANTED: begin
      end
      default: begin
        w_state = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_COLLECT;
      r_entry     <= '0;
      r_count     <= '0;
      r_tries     <= TRIES_INIT;
      r_pass_ok   <= 1'b0;
      r_pass_fail <= 1'b0;
      r_digit_err <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_entry     <= w_entry;
      r_count     <= w_count;
      r_tries     <= w_tries;
      r_pass_ok   <= w_pass_ok;
      r_pass_fail <= w_pass_fail;
      r_digit_err <= w_digit_err;
      r_locked    <= w_locked;
    end
  end

  assign digit_count = r_count;
  assign entry       = r_entry;
  assign pass_ok     = r_pass_ok;
  assign pass_fail   = r_pass_fail;
  assign digit_err   = r_digit_err;
  assign locked      = r_locked;
  assign tries_left  = r_tries;

endmodule

// File: tb/tb_password_check.sv
// Self-checking bench for password_check with an attempt-level model.
// Uses LOCK_CYCLES=10 so lockout windows stay short.
module tb_password_check;

  localparam logic [15:0] PW = 16'h1357;
  localparam int MAXT = 3;
  localparam int LC = 10;

  logic        clk;
  logic        rst;
  logic        enter_pulse;
  logic [3:0]  digit_in;
  logic [1:0]  digit_count;
  logic [15:0] entry;
  logic        pass_ok;
  logic        pass_fail;
  logic        digit_err;
  logic        locked;
  logic [1:0]  tries_left;

  int n_tests = 0;
  int n_fail  = 0;

  password_check #(
    .PASSWORD    (PW),
    .MAX_TRIES   (MAXT),
    .LOCK_CYCLES (LC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enter_pulse (enter_pulse),
    .digit_in    (digit_in),
    .digit_count (digit_count),
    .entry       (entry),
    .pass_ok     (pass_ok),
    .pass_fail   (pass_fail),
    .digit_err   (digit_err),
    .locked      (locked),
    .tries_left  (tries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] d);
    enter_pulse = 1'b1;
    digit_in    = d;
    step();
    enter_pulse = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic enter_code(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    for (int k = 0; k < 4; k++) begin
      strobe(v[15:12]);
      v = v << 4;
    end
  endtask

  task automatic lock_len(output int n, input logic poke,
                          input logic [15:0] hold, output int bad);
    n = 1;
    bad = 0;
    while (locked === 1'b1 && n <= LC + 20) begin
      if (poke) begin
        enter_pulse = 1'b1;
        digit_in = 4'($urandom_range(0, 15));
      end
      step();
      if (locked === 1'b1) begin
        n++;
        if (entry !== hold || digit_err !== 1'b0) bad++;
      end
    end
    enter_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enter_pulse = 1'b0;
    digit_in = 4'd0;
    #2 rst = 1'b0;
    #2;
    n_tests++;
    if ({entry, digit_count, pass_ok, pass_fail, digit_err, locked}
        !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_zero: got %h/%0d/%b%b%b%b required 0",
               entry, digit_count, pass_ok, pass_fail, digit_err, locked);
    end
    n_tests++;
    if (tries_left !== 2'(MAXT)) begin
      n_fail++;
      $display("FAIL reset_tries: got %0d required %0d", tries_left, MAXT);
    end
    enter_pulse = 1'b1;
    digit_in = 4'd4;
    step();
    step();
    n_tests++;
    if (digit_count !== 2'd0 || entry !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %0d/%h required 0/0",
               digit_count, entry);
    end
    #2 rst = 1'b1;
    step();
    enter_pulse = 1'b0;
    n_tests++;
    if (digit_count !== 2'd1 || entry !== 16'h0004) begin
      n_fail++;
      $display("FAIL first_capture: got %0d/%h required 1/0004",
               digit_count, entry);
    end
  endtask

  task automatic test_correct();
    do_reset();
    strobe(4'd1); strobe(4'd3); strobe(4'd5); strobe(4'd7);
    n_tests++;
    if (pass_ok !== 1'b0 || digit_count !== 2'd0 || entry !== PW) begin
      n_fail++;
      $display("FAIL ok_early: got ok=%b cnt=%0d e=%h required 0/0/%h",
               pass_ok, digit_count, entry, PW);
    end
    step();
    n_tests++;
    if (pass_ok !== 1'b1 || tries_left !== 2'd3) begin
      n_fail++;
      $display("FAIL ok_latency: got ok=%b tries=%0d required 1/3",
               pass_ok, tries_left);
    end
    strobe(4'd2);
    step(); step();
    n_tests++;
    if (pass_ok !== 1'b1 || entry !== PW || digit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ok_hold: got ok=%b e=%h required 1/%h",
               pass_ok, entry, PW);
    end
  endtask

  task automatic test_wrong();
    int pulses;
    do_reset();
    enter_code(16'h1358);
    pulses = 0;
    step();
    n_tests++;
    if (pass_fail !== 1'b1 || tries_left !== 2'd2) begin
      n_fail++;
      $display("FAIL wrong_pulse: got pf=%b tries=%0d required 1/2",
               pass_fail, tries_left);
    end
    if (pass_fail === 1'b1) pulses++;
    step();
    if (pass_fail === 1'b1) pulses++;
    n_tests++;
    if (entry !== 16'h0 || pass_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL wrong_clear: got e=%h ok=%b required 0/0",
               entry, pass_ok);
    end
    strobe(4'd6);
    if (pass_fail === 1'b1) pulses++;
    step();
    if (pass_fail === 1'b1) pulses++;
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL wrong_count: got %0d pulses required 1", pulses);
    end
    n_tests++;
    if (digit_count !== 2'd1 || entry !== 16'h0006) begin
      n_fail++;
      $display("FAIL wrong_collect: got %0d/%h required 1/0006",
               digit_count, entry);
    end
  endtask

  task automatic test_lockout();
    int n;
    int bad;
    do_reset();
    for (int a = 0; a < 3; a++) begin
      enter_code(16'h2468);
      step();
      step();
    end
    n_tests++;
    if (locked !== 1'b1 || tries_left !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_enter: got l=%b tries=%0d required 1/0",
               locked, tries_left);
    end
    lock_len(n, 1'b1, 16'h2468, bad);
    n_tests++;
    if (n !== LC) begin
      n_fail++;
      $display("FAIL lock_len: got %0d cycles required %0d", n, LC);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL lock_ignore: got %0d bad cycles required 0", bad);
    end
    n_tests++;
    if (tries_left !== 2'd3 || entry !== 16'h0) begin
      n_fail++;
      $display("FAIL lock_exit: got tries=%0d e=%h required 3/0",
               tries_left, entry);
    end
    enter_code(PW);
    step();
    n_tests++;
    if (pass_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_relogin: got %b required 1", pass_ok);
    end
  endtask

  task automatic test_digit_err();
    do_reset();
    strobe(4'd1);
    strobe(4'hA);
    n_tests++;
    if (digit_err !== 1'b1 || digit_count !== 2'd1 ||
        entry !== 16'h0001) begin
      n_fail++;
      $display("FAIL derr_pulse: got de=%b cnt=%0d e=%h required 1/1/0001",
               digit_err, digit_count, entry);
    end
    step();
    n_tests++;
    if (digit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL derr_width: got %b required 0", digit_err);
    end
    strobe(4'd3); strobe(4'd5); strobe(4'd7);
    step();
    n_tests++;
    if (pass_ok !== 1'b1 || entry !== PW) begin
      n_fail++;
      $display("FAIL derr_ok: got ok=%b e=%h required 1/%h",
               pass_ok, entry, PW);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    strobe(4'd1);
    strobe(4'd2);
    #3 rst = 1'b0;
    #1;
    n_tests++;
    if (entry !== 16'h0 || digit_count !== 2'd0 ||
        tries_left !== 2'd3) begin
      n_fail++;
      $display("FAIL areset_mid: got e=%h cnt=%0d t=%0d required 0/0/3",
               entry, digit_count, tries_left);
    end
    #1 rst = 1'b1;
    for (int a = 0; a < 3; a++) begin
      enter_code(16'h9999);
      step();
      step();
    end
    step(); step(); step();
    #3 rst = 1'b0;
    #1;
    n_tests++;
    if (locked !== 1'b0 || tries_left !== 2'd3 || entry !== 16'h0 ||
        pass_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_lock: got l=%b t=%0d e=%h required 0/3/0",
               locked, tries_left, entry);
    end
    #1 rst = 1'b1;
    strobe(4'd8);
    n_tests++;
    if (digit_count !== 2'd1 || entry !== 16'h0008) begin
      n_fail++;
      $display("FAIL areset_cap: got %0d/%h required 1/0008",
               digit_count, entry);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enter_pulse = 1'b1;
    digit_in = 4'd1; step();
    digit_in = 4'd3; step();
    digit_in = 4'd5; step();
    digit_in = 4'd8; step();
    digit_in = 4'hB; step();
    n_tests++;
    if (entry !== 16'h1358 || digit_err !== 1'b0 ||
        pass_fail !== 1'b1) begin
      n_fail++;
      $display("FAIL check_ignore: got e=%h de=%b pf=%b required 1358/0/1",
               entry, digit_err, pass_fail);
    end
    digit_in = 4'd9; step();
    n_tests++;
    if (entry !== 16'h0 || digit_count !== 2'd0) begin
      n_fail++;
      $display("FAIL denied_ignore: got e=%h cnt=%0d required 0/0",
               entry, digit_count);
    end
    step();
    enter_pulse = 1'b0;
    n_tests++;
    if (entry !== 16'h0009 || digit_count !== 2'd1) begin
      n_fail++;
      $display("FAIL held_capture: got e=%h cnt=%0d required 0009/1",
               entry, digit_count);
    end
  endtask

  task automatic test_random();
    logic [15:0] code;
    logic [3:0]  dg;
    int m_tries;
    int n;
    int bad;
    do_reset();
    m_tries = MAXT;
    for (int a = 0; a < 40; a++) begin
      code = 16'h0;
      for (int k = 0; k < 4; k++)
        code = {code[11:0], 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 2) == 0) code = PW;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          strobe(4'($urandom_range(10, 15)));
          n_tests++;
          if (digit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_derr: got %b required 1", digit_err);
          end
        end
        dg = code[15 - 4*k -: 4];
        strobe(dg);
        n_tests++;
        if (digit_count !== 2'(k + 1) || digit_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_count: got %0d/%b required %0d/0",
                   digit_count, digit_err, (k + 1) % 4);
        end
        if (k < 3) repeat ($urandom_range(0, 2)) step();
      end
      step();
      if (code == PW) begin
        n_tests++;
        if (pass_ok !== 1'b1 || pass_fail !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_ok: got ok=%b pf=%b required 1/0",
                   pass_ok, pass_fail);
        end
        do_reset();
        m_tries = MAXT;
      end else begin
        m_tries--;
        n_tests++;
        if (pass_fail !== 1'b1 || tries_left !== 2'(m_tries)) begin
          n_fail++;
          $display("FAIL rnd_fail: got pf=%b t=%0d required 1/%0d",
                   pass_fail, tries_left, m_tries);
        end
        step();
        if (m_tries == 0) begin
          n_tests++;
          if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_lock: got %b required 1", locked);
          end
          lock_len(n, 1'b0, code, bad);
          n_tests++;
          if (n !== LC || tries_left !== 2'(MAXT)) begin
            n_fail++;
            $display("FAIL rnd_locklen: got %0d/%0d required %0d/%0d",
                     n, tries_left, LC, MAXT);
          end
          m_tries = MAXT;
        end else begin
          n_tests++;
          if (entry !== 16'h0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_retry: got e=%h l=%b required 0/0",
                     entry, locked);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_lockout();
    test_digit_err();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
